pipelined_stage2_align: RTL and testbench
=========================================

Name: pipelined_stage2_align

Overview:
Second stage of the add/sub pipeline. It consumes the partitioned operands and the exponent-difference and compare results of stage 1. It selects the larger-magnitude operand, right-shifts the smaller mantissa into a guard/round/sticky-extended field, and computes the tentative result exponent and sign. The aligned pair is registered through a valid/ready handshake with a one-entry skid buffer and feeds the mantissa add/sub stage.

Parameters:
FractionSize, 23, fraction width
MantissaSize, FractionSize+1, mantissa width (hidden 1 included)
RoundingSize, MantissaSize+3, mantissa plus guard, round and sticky bits
ExponentSize, 8, exponent width
ShiftSize, ExponentSize-3, width of Difference/NDifference (5)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
InValid  input  1  stage-1 data valid
InReady  output  1  stage can accept input
Exponent1, Exponent2  input  ExponentSize  biased exponents
Mantissa1, Mantissa2  input  MantissaSize  {1,fraction}
OperandSign1, OperandSign2  input  1  operand signs
Operation  input  1  0 add, 1 subtract
EffOperation  input  1  effective operation
Compare  input  2  01: M1>M2, 10: M1<M2, 00: equal
Difference  input  ShiftSize  Exponent1-Exponent2 when SignOfDifference=0
NDifference  input  ShiftSize  Exponent2-Exponent1 when SignOfDifference=1
SignOfDifference  input  1  1: Exponent2>Exponent1
ZeroDifference  input  1  exponents equal
OutValid  output  1  output data valid
OutReady  input  1  downstream accepts
LargeMantissa  output  RoundingSize  {larger mantissa,3'b000}
SmallMantissa  output  RoundingSize  aligned smaller mantissa, LSB = sticky
ResultExponent  output  ExponentSize  larger exponent
ResultSign  output  1  tentative result sign
EffOperationOut  output  1  registered EffOperation
Swapped  output  1  1: operand 2 is the larger
ExactZero  output  1  subtraction of equal magnitudes

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high. On Reset, OutValid=0, the skid buffer is empty, InReady=1, and all data outputs are 0.
- Selection: Swapped = SignOfDifference | (ZeroDifference & Compare==2'b10). Shift amount = SignOfDifference ? NDifference : (ZeroDifference ? 0 : Difference).
- Large operand: LargeMantissa = {larger mantissa, 3'b000}. ResultExponent = larger exponent.
- Sign: ResultSign = Swapped ? (OperandSign2 ^ Operation) : OperandSign1.
- Alignment: Ext = {smaller mantissa, 3'b000}. Sh = Ext >> s. SmallMantissa = {Sh[26:1], Sh[0] | OR(bits shifted out)}.
- Large shifts: for s >= RoundingSize (27..31), SmallMantissa = 27'h0000001. The sticky is set because the mantissa is nonzero.
- Exact zero: ExactZero = EffOperation & ZeroDifference & (Compare==2'b00). When it is set, ResultSign is forced to 0 (round-to-nearest +0).
- Latency: 1 cycle from input acceptance (InValid & InReady) to OutValid.
- Output register: loads when !OutValid | OutReady. If it is stalled while input is accepted, the input goes to the skid buffer.
- Skid buffer: InReady = !SkidFull, registered, so it does not depend combinationally on OutReady.
  - When the output drains and the skid is full, the skid contents move to the output register and SkidFull clears in the same cycle.
  - Input is accepted that cycle only if InReady was 1.
- Ordering: strict FIFO order. No entry is dropped or duplicated.
- Simultaneous events: output drain, skid transfer and new input can occur on the same edge and must all be honoured.
- Stability: output data is held stable while OutValid & !OutReady.
- Reset mid-operation: Reset overrides all handshake activity. Any in-flight entries are discarded.

Decomposition:
- Shared package (fp_addsub_pkg): the size constants (FractionSize, MantissaSize, RoundingSize, ExponentSize, ShiftSize) and the Compare encodings (CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10).
- Sub-module align_shifter: combinational, takes MantissaSize mantissa and ShiftSize amount, returns the RoundingSize result with sticky. Reused later by normalisation.

Test Plan:
- Basic alignment: Op1=3.0 (E=0x80, M=0xC00000), Op2=1.0 (E=0x7F, M=0x800000), add, Difference=1, Sign=0 -> after 1 cycle LargeMantissa=27'h6000000, SmallMantissa=27'h2000000, ResultExponent=0x80, Swapped=0, ResultSign=0.
- Swap with subtract: Op1=1.0, Op2=3.0, Operation=1, SignOfDifference=1, NDifference=1 -> Swapped=1, LargeMantissa=27'h6000000, SmallMantissa=27'h2000000, ResultSign=1.
- Sticky capture: smaller M=0x800001, s=25 -> SmallMantissa=27'h0000003. With s=31 -> SmallMantissa=27'h0000001.
- Exact cancellation: both operands 0x3F800000, Operation=1, ZeroDifference=1, Compare=00 -> ExactZero=1, ResultSign=0, SmallMantissa=LargeMantissa=27'h4000000.
- Backpressure: InValid held high with 4 distinct operands, OutReady=0 for 3 cycles -> InReady falls after 2 accepts. After OutReady returns, all 4 results appear in order, none lost or duplicated, and data is stable while stalled.
- Reset mid-operation: OutValid=1 and skid full, assert Reset for 1 cycle -> next edge OutValid=0, InReady=1, outputs 0. Nothing from before the reset emerges afterwards.

Source files
------------

// File: rtl/fp_addsub_pkg.sv
// Shared sizes, compare encodings and the stage-2 payload for the add/sub pipeline.
package fp_addsub_pkg;

    localparam int FractionSize = 23;
    localparam int MantissaSize = FractionSize + 1;
    localparam int RoundingSize = MantissaSize + 3;
    localparam int ExponentSize = 8;
    localparam int ShiftSize    = ExponentSize - 3;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef struct packed {
        logic [RoundingSize-1:0] large_mant;
        logic [RoundingSize-1:0] small_mant;
        logic [ExponentSize-1:0] exp;
        logic                    sign;
        logic                    eff_op;
        logic                    swapped;
        logic                    exact_zero;
    } align_t;

endpackage

// File: rtl/pipelined_stage2_align_shifter.sv
// Right-shifts {mantissa,3'b000} and folds every bit shifted out into the LSB (sticky).
module align_shifter
    import fp_addsub_pkg::*;
(
    input  logic [MantissaSize-1:0] mantissa,
    input  logic [ShiftSize-1:0]    shift,
    output logic [RoundingSize-1:0] aligned
);

    logic [RoundingSize-1:0] ext;
    logic [RoundingSize-1:0] shifted;
    logic [RoundingSize-1:0] lost_mask;
    logic                    sticky;

    always_comb begin
        ext       = {mantissa, 3'b000};
        shifted   = ext >> shift;
        // Shifts past the field width leave an all-ones mask, so sticky covers the whole operand.
        lost_mask = ~({RoundingSize{1'b1}} << shift);
        sticky    = |(ext & lost_mask);
        aligned   = {shifted[RoundingSize-1:1], shifted[0] | sticky};
    end

endmodule

// File: rtl/pipelined_stage2_align.sv
// Add/sub stage 2: operand swap, mantissa alignment with sticky, tentative exponent/sign,
// registered through a valid/ready output register backed by a one-entry skid buffer.
module pipelined_stage2_align
    import fp_addsub_pkg::*;
(
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [ExponentSize-1:0] Exponent1,
    input  logic [ExponentSize-1:0] Exponent2,
    input  logic [MantissaSize-1:0] Mantissa1,
    input  logic [MantissaSize-1:0] Mantissa2,
    input  logic                    OperandSign1,
    input  logic                    OperandSign2,
    input  logic                    Operation,
    input  logic                    EffOperation,
    input  logic [1:0]              Compare,
    input  logic [ShiftSize-1:0]    Difference,
    input  logic [ShiftSize-1:0]    NDifference,
    input  logic                    SignOfDifference,
    input  logic                    ZeroDifference,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [RoundingSize-1:0] LargeMantissa,
    output logic [RoundingSize-1:0] SmallMantissa,
    output logic [ExponentSize-1:0] ResultExponent,
    output logic                    ResultSign,
    output logic                    EffOperationOut,
    output logic                    Swapped,
    output logic                    ExactZero
);

    logic                    swap;
    logic                    exact;
    logic [ShiftSize-1:0]    shamt;
    logic [MantissaSize-1:0] small_src;
    logic [RoundingSize-1:0] small_aligned;
    align_t                  in_d;
    align_t                  out_q;
    align_t                  skid_q;
    logic                    out_valid;
    logic                    skid_full;
    logic                    accept;

    always_comb begin
        swap      = SignOfDifference | (ZeroDifference & (Compare == CMP_LT));
        shamt     = SignOfDifference ? NDifference : (ZeroDifference ? '0 : Difference);
        small_src = swap ? Mantissa1 : Mantissa2;
        exact     = EffOperation & ZeroDifference & (Compare == CMP_EQ);
    end

    align_shifter u_shift (
        .mantissa (small_src),
        .shift    (shamt),
        .aligned  (small_aligned)
    );

    always_comb begin
        in_d.large_mant = {(swap ? Mantissa2 : Mantissa1), 3'b000};
        in_d.small_mant = small_aligned;
        in_d.exp        = swap ? Exponent2 : Exponent1;
        // Exact cancellation yields +0 under round-to-nearest.
        in_d.sign       = exact ? 1'b0 : (swap ? (OperandSign2 ^ Operation) : OperandSign1);
        in_d.eff_op     = EffOperation;
        in_d.swapped    = swap;
        in_d.exact_zero = exact;
    end

    assign InReady = ~skid_full;
    assign accept  = InValid & ~skid_full;

    // Skid and input acceptance are mutually exclusive, so a draining output takes the skid first.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_q     <= '0;
            skid_full <= 1'b0;
            skid_q    <= '0;
        end else if (!out_valid || OutReady) begin
            if (skid_full) begin
                out_q     <= skid_q;
                out_valid <= 1'b1;
                skid_full <= 1'b0;
            end else if (accept) begin
                out_q     <= in_d;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q    <= in_d;
            skid_full <= 1'b1;
        end
    end

    assign OutValid        = out_valid;
    assign LargeMantissa   = out_q.large_mant;
    assign SmallMantissa   = out_q.small_mant;
    assign ResultExponent  = out_q.exp;
    assign ResultSign      = out_q.sign;
    assign EffOperationOut = out_q.eff_op;
    assign Swapped         = out_q.swapped;
    assign ExactZero       = out_q.exact_zero;

endmodule

// File: tb/tb_pipelined_stage2_align.sv
// Self-checking bench for pipelined_stage2_align: directed spec cases plus randomized traffic
// against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_stage2_align;
    import fp_addsub_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset, InValid, InReady, OutValid, OutReady;
    logic [7:0]  Exponent1, Exponent2, ResultExponent;
    logic [23:0] Mantissa1, Mantissa2;
    logic        OperandSign1, OperandSign2, Operation, EffOperation;
    logic [1:0]  Compare;
    logic [4:0]  Difference, NDifference;
    logic        SignOfDifference, ZeroDifference;
    logic [26:0] LargeMantissa, SmallMantissa;
    logic        ResultSign, EffOperationOut, Swapped, ExactZero;

    int n_pass = 0;
    int n_total = 0;

    typedef struct packed {
        logic [7:0]  e1, e2;
        logic [23:0] m1, m2;
        logic        s1, s2, op;
    } op_t;

    typedef struct packed {
        logic [26:0] lm, sm;
        logic [7:0]  ex;
        logic        sg, eff, sw, ez;
    } res_t;

    res_t exp_q[$];

    pipelined_stage2_align dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Exponent1(Exponent1), .Exponent2(Exponent2),
        .Mantissa1(Mantissa1), .Mantissa2(Mantissa2),
        .OperandSign1(OperandSign1), .OperandSign2(OperandSign2),
        .Operation(Operation), .EffOperation(EffOperation), .Compare(Compare),
        .Difference(Difference), .NDifference(NDifference),
        .SignOfDifference(SignOfDifference), .ZeroDifference(ZeroDifference),
        .OutValid(OutValid), .OutReady(OutReady),
        .LargeMantissa(LargeMantissa), .SmallMantissa(SmallMantissa),
        .ResultExponent(ResultExponent), .ResultSign(ResultSign),
        .EffOperationOut(EffOperationOut), .Swapped(Swapped), .ExactZero(ExactZero)
    );

    always #5 Clock = ~Clock;

    // Reference: compare magnitudes directly, align by wide integer shift.
    function automatic res_t model(op_t o);
        res_t        r;
        logic [63:0] full;
        logic        sw;
        int          s;
        sw   = (o.e2 > o.e1) || ((o.e1 == o.e2) && (o.m2 > o.m1));
        s    = (o.e1 > o.e2) ? int'(o.e1) - int'(o.e2) : int'(o.e2) - int'(o.e1);
        full = {5'b0, (sw ? o.m1 : o.m2), 3'b000, 32'b0};
        full = full >> s;
        r.sm  = full[58:32] | 27'(|full[31:0]);
        r.lm  = {(sw ? o.m2 : o.m1), 3'b000};
        r.ex  = sw ? o.e2 : o.e1;
        r.eff = o.s1 ^ o.s2 ^ o.op;
        r.sw  = sw;
        r.ez  = r.eff && (o.e1 == o.e2) && (o.m1 == o.m2);
        r.sg  = r.ez ? 1'b0 : (sw ? (o.s2 ^ o.op) : o.s1);
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.lm = LargeMantissa; r.sm = SmallMantissa; r.ex = ResultExponent;
        r.sg = ResultSign; r.eff = EffOperationOut; r.sw = Swapped; r.ez = ExactZero;
        return r;
    endfunction

    function automatic op_t mk(logic [7:0] e1, logic [23:0] m1, logic s1,
                               logic [7:0] e2, logic [23:0] m2, logic s2, logic op);
        op_t o;
        o.e1 = e1; o.m1 = m1; o.s1 = s1; o.e2 = e2; o.m2 = m2; o.s2 = s2; o.op = op;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  e1, d;
        e1 = int'($urandom_range(40, 200));
        d  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
        o.e1 = 8'(e1);
        o.e2 = ($urandom_range(0, 1) == 1) ? 8'(e1 + d) : 8'(e1 - d);
        o.m1 = {1'b1, 23'($urandom)};
        o.m2 = ($urandom_range(0, 3) == 0) ? o.m1 : {1'b1, 23'($urandom)};
        o.s1 = 1'($urandom); o.s2 = 1'($urandom); o.op = 1'($urandom);
        return o;
    endfunction

    // Drive the stage-1 fields that correspond to an operand pair.
    task automatic apply(input op_t o);
        logic [7:0] d, nd;
        d  = o.e1 - o.e2;
        nd = o.e2 - o.e1;
        Exponent1 = o.e1; Exponent2 = o.e2; Mantissa1 = o.m1; Mantissa2 = o.m2;
        OperandSign1 = o.s1; OperandSign2 = o.s2; Operation = o.op;
        EffOperation = o.s1 ^ o.s2 ^ o.op;
        Compare = (o.m1 > o.m2) ? 2'b01 : ((o.m1 < o.m2) ? 2'b10 : 2'b00);
        Difference = d[4:0];
        NDifference = nd[4:0];
        SignOfDifference = o.e2 > o.e1;
        ZeroDifference = o.e1 == o.e2;
    endtask

    task automatic run_one(input op_t o, output res_t got, output int lat);
        lat = -1;
        got = '0;
        @(negedge Clock);
        apply(o); InValid = 1'b1; OutReady = 1'b1;
        for (int i = 0; i < 8 && !InReady; i++) @(negedge Clock);
        @(negedge Clock);
        InValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (OutValid) begin got = observed(); lat = i; break; end
            @(negedge Clock);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        apply(mk(8'h80, 24'hC00000, 1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0));
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        n_total++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || observed() !== '0)
            $display("FAIL reset: OutValid=%b InReady=%b data=%h, want 0/1/0", OutValid, InReady, observed());
        else n_pass++;
        Reset = 1'b0;
    endtask

    task automatic test_directed(input string name, input op_t o, input res_t want);
        res_t got;
        int   lat;
        run_one(o, got, lat);
        n_total++;
        if (lat !== 0) $display("FAIL %s latency: got %0d extra cycles, want 0", name, lat);
        else n_pass++;
        n_total++;
        if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
        else n_pass++;
        n_total++;
        if (model(o) !== want) $display("FAIL %s model: got %h want %h", name, model(o), want);
        else n_pass++;
    endtask

    task automatic test_alignment();
        test_directed("basic", mk(8'h80, 24'hC00000, 1'b0, 8'h7F, 24'h800000, 1'b0, 1'b0),
                      {27'h6000000, 27'h2000000, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0});
        test_directed("swap_sub", mk(8'h7F, 24'h800000, 1'b0, 8'h80, 24'hC00000, 1'b0, 1'b1),
                      {27'h6000000, 27'h2000000, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0});
    endtask

    task automatic test_sticky();
        test_directed("sticky_s24", mk(8'h98, 24'h800000, 1'b0, 8'h80, 24'h800001, 1'b0, 1'b0),
                      {27'h4000000, 27'h0000005, 8'h98, 1'b0, 1'b0, 1'b0, 1'b0});
        test_directed("sticky_s25", mk(8'h99, 24'h800000, 1'b0, 8'h80, 24'h800001, 1'b0, 1'b0),
                      {27'h4000000, 27'h0000003, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0});
        test_directed("sticky_s27", mk(8'h9B, 24'h800000, 1'b0, 8'h80, 24'h800001, 1'b0, 1'b0),
                      {27'h4000000, 27'h0000001, 8'h9B, 1'b0, 1'b0, 1'b0, 1'b0});
        test_directed("sticky_s31", mk(8'h9F, 24'h800000, 1'b1, 8'h80, 24'h800001, 1'b0, 1'b0),
                      {27'h4000000, 27'h0000001, 8'h9F, 1'b1, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic test_exact_zero();
        test_directed("exact_zero", mk(8'h7F, 24'h800000, 1'b0, 8'h7F, 24'h800000, 1'b0, 1'b1),
                      {27'h4000000, 27'h4000000, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1});
        test_directed("exact_zero_neg", mk(8'h7F, 24'h800000, 1'b1, 8'h7F, 24'h800000, 1'b1, 1'b1),
                      {27'h4000000, 27'h4000000, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1});
        test_directed("equal_add", mk(8'h7F, 24'h800000, 1'b1, 8'h7F, 24'h800000, 1'b1, 1'b0),
                      {27'h4000000, 27'h4000000, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic test_backpressure();
        op_t  ops[4];
        res_t held, got, want;
        int   idx = 0, rcvd = 0, acc_at_full = -1;
        bit   stall_prev = 1'b0;
        int   bad_stable = 0, bad_order = 0;
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            ops[k] = mk(8'(8'h80 + k), {1'b1, 23'(k * 4099 + 7)}, 1'b0, 8'h7E, 24'h900000, 1'b1, 1'b0);
        for (int c = 0; c < 20 && rcvd < 4; c++) begin
            @(negedge Clock);
            OutReady = (c >= 3);
            InValid  = (idx < 4);
            if (idx < 4) apply(ops[idx]);
            #1;
            if (stall_prev && (OutValid !== 1'b1 || observed() !== held)) bad_stable++;
            if (InValid && !InReady && acc_at_full < 0) acc_at_full = idx;
            if (OutValid && OutReady) begin
                got = observed();
                if (exp_q.size() == 0) bad_order++;
                else begin
                    want = exp_q.pop_front();
                    if (got !== want) bad_order++;
                end
                rcvd++;
            end
            if (InValid && InReady) begin exp_q.push_back(model(ops[idx])); idx++; end
            stall_prev = OutValid && !OutReady;
            held = observed();
        end
        InValid = 1'b0;
        n_total++;
        if (acc_at_full !== 2) $display("FAIL bp_inready_fall: accepts before stall %0d, want 2", acc_at_full);
        else n_pass++;
        n_total++;
        if (bad_stable !== 0) $display("FAIL bp_stable: %0d unstable stall cycles, want 0", bad_stable);
        else n_pass++;
        n_total++;
        if (bad_order !== 0 || rcvd !== 4)
            $display("FAIL bp_order: %0d wrong, %0d received, want 0 wrong 4 received", bad_order, rcvd);
        else n_pass++;
    endtask

    task automatic test_random();
        op_t  cur;
        res_t held, want, got;
        bit   stall_prev = 1'b0;
        int   bad = 0, bad_stable = 0, rcvd = 0, sent = 0;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge Clock);
            cur      = rand_op();
            apply(cur);
            InValid  = (c < 560) && ($urandom_range(0, 3) != 0);
            OutReady = (c >= 560) || ($urandom_range(0, 2) != 0);
            #1;
            if (stall_prev && (OutValid !== 1'b1 || observed() !== held)) bad_stable++;
            if (OutValid && OutReady) begin
                got = observed();
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL random_extra: got %h with empty scoreboard", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL random_data #%0d: got %h want %h", rcvd, got, want);
                    end
                end
                rcvd++;
            end
            if (InValid && InReady) begin exp_q.push_back(model(cur)); sent++; end
            stall_prev = OutValid && !OutReady;
            held = observed();
        end
        InValid = 1'b0;
        n_total++;
        if (bad !== 0) $display("FAIL random: %0d bad of %0d, want 0", bad, rcvd);
        else n_pass++;
        n_total++;
        if (bad_stable !== 0) $display("FAIL random_stable: %0d unstable cycles, want 0", bad_stable);
        else n_pass++;
        n_total++;
        if (rcvd !== sent || exp_q.size() !== 0)
            $display("FAIL random_count: received %0d of %0d sent, want all", rcvd, sent);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        res_t got;
        int   lat, leaked = 0;
        op_t  fresh;
        @(negedge Clock);
        OutReady = 1'b0; InValid = 1'b1;
        apply(mk(8'h90, 24'hABCDEF, 1'b1, 8'h88, 24'h812345, 1'b0, 1'b0));
        @(negedge Clock);
        apply(mk(8'h70, 24'hF00000, 1'b0, 8'h71, 24'h800000, 1'b1, 1'b1));
        @(negedge Clock);
        n_total++;
        if (OutValid !== 1'b1 || InReady !== 1'b0)
            $display("FAIL mid_precond: OutValid=%b InReady=%b, want 1/0", OutValid, InReady);
        else n_pass++;
        Reset = 1'b1;
        apply(mk(8'h60, 24'hC00000, 1'b0, 8'h60, 24'h800000, 1'b0, 1'b0));
        @(negedge Clock);
        n_total++;
        if (OutValid !== 1'b0 || InReady !== 1'b1 || observed() !== '0)
            $display("FAIL mid_reset: OutValid=%b InReady=%b data=%h, want 0/1/0", OutValid, InReady, observed());
        else n_pass++;
        Reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clock);
            if (OutValid) leaked++;
        end
        n_total++;
        if (leaked !== 0) $display("FAIL mid_leak: %0d stale outputs, want 0", leaked);
        else n_pass++;
        fresh = mk(8'h85, 24'h8F0F0F, 1'b0, 8'h85, 24'hF0F0F0, 1'b1, 1'b0);
        run_one(fresh, got, lat);
        n_total++;
        if (lat !== 0 || got !== model(fresh))
            $display("FAIL mid_fresh: got %h lat %0d, want %h lat 0", got, lat, model(fresh));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alignment();
        test_sticky();
        test_exact_zero();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
